// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline front end: fetch FSM states and fetch constants.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_perf_cnt.sv
// Saturating event counter used for the optional fetch performance outputs (IF_PERF_EN).
module if_perf_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests, and fills the IF/ID slot.
// Optional performance counters are built when IF_PERF_EN is defined.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned       XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_valid,
`ifdef IF_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall_cyc,
  output logic [31:0]     perf_killed,
`endif
  output logic            if_flush
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            slot_valid_q, slot_valid_d;
  logic [XLEN-1:0] slot_pc_q, slot_pc_d;
  logic [XLEN-1:0] slot_instr_q, slot_instr_d;

  logic consume;
  logic fill;
  logic discard;

  assign consume = slot_valid_q && !stall;
  assign fill    = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
  assign discard = imem_rsp_valid && ((state_q == KILL) ||
                                      ((state_q == WAIT) && redirect_valid));

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a response that arrives while killing always retires the outstanding request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ: begin
        if (imem_req_valid && imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid)      state_d = REQ;
        else if (redirect_valid) state_d = KILL;
      end
      KILL: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req_valid = 1'b0;
    if ((state_q == REQ) && (!slot_valid_q || !stall) && !redirect_valid && reset_n) begin
      imem_req_valid = 1'b1;
    end
  end

  // PC and slot update; redirect overrides fill and consume
  always_comb begin
    pc_d         = pc_q;
    slot_valid_d = slot_valid_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    if (redirect_valid) begin
      pc_d         = redirect_pc & ~XLEN'(3);
      slot_valid_d = 1'b0;
      slot_pc_d    = '0;
      slot_instr_d = XLEN'(BUBBLE_INSTR);
    end else if (fill) begin
      pc_d         = pc_q + XLEN'(PC_INCR);
      slot_valid_d = 1'b1;
      slot_pc_d    = pc_q;
      slot_instr_d = imem_rsp_data;
    end else if (consume) begin
      slot_valid_d = 1'b0;
      slot_pc_d    = '0;
      slot_instr_d = XLEN'(BUBBLE_INSTR);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      slot_valid_q <= 1'b0;
      slot_pc_q    <= '0;
      slot_instr_q <= XLEN'(BUBBLE_INSTR);
    end else begin
      pc_q         <= pc_d;
      slot_valid_q <= slot_valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign if_pc         = slot_pc_q;
  assign if_instr      = slot_instr_q;
  assign if_valid      = slot_valid_q;
  assign if_flush      = redirect_valid;

`ifdef IF_PERF_EN
  if_perf_cnt #(.WIDTH(32)) u_cnt_fetched (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (fill),
    .count_o (perf_fetched)
  );

  if_perf_cnt #(.WIDTH(32)) u_cnt_stall (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (slot_valid_q && stall),
    .count_o (perf_stall_cyc)
  );

  if_perf_cnt #(.WIDTH(32)) u_cnt_killed (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (discard),
    .count_o (perf_killed)
  );
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit: inputs change 1ns after posedge, outputs checked mid-cycle.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_flush;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_killed;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
`ifdef IF_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_killed    (perf_killed),
`endif
    .if_flush       (if_flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(if_valid), 32'(v));
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, instr);
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'(v));
    if (v) chk({tag, "_req_addr"}, imem_req_addr, addr);
  endtask

  initial begin
    reset_n        = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    tick(); tick();
    settle();
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk_slot("rst", 1'b0, 32'h0, 32'h0);

    // Cycle 0: release reset, first request to RESET_PC
    tick();
    reset_n = 1'b1;
    settle();
    chk_req("c0", 1'b1, 32'h0);

    // Cycle 1: WAIT, response arrives
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    settle();
    chk_req("c1_wait", 1'b0, 32'h0);

    // Cycle 2: slot full; stall for 3 cycles
    tick();
    imem_rsp_valid = 1'b0;
    stall = 1'b1;
    settle();
    chk_slot("c2_first", 1'b1, 32'h0, 32'h0050_0093);
    chk_req("c2_stall", 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      settle();
      chk_slot("stall_hold", 1'b1, 32'h0, 32'h0050_0093);
      chk_req("stall_noreq", 1'b0, 32'h0);
    end

    // Cycle 5: stall drops, request to pc+4 in the same cycle
    tick();
    stall = 1'b0;
    settle();
    chk_req("c5_unstall", 1'b1, 32'h4);

    // Cycle 6: WAIT, slot consumed; redirect while waiting
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    settle();
    chk_slot("c6_bubble", 1'b0, 32'h0, 32'h0);
    chk("c6_flush", 32'(if_flush), 32'h1);
    chk_req("c6_redir", 1'b0, 32'h0);

    // Cycle 7: KILL, stale response arrives
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    settle();
    chk("c7_flush", 32'(if_flush), 32'h0);
    chk_slot("c7_flushed", 1'b0, 32'h0, 32'h0);
    chk_req("c7_kill", 1'b0, 32'h0);

    // Cycle 8: stale data discarded, request to aligned redirect target
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    chk_slot("c8_discard", 1'b0, 32'h0, 32'h0);
    chk_req("c8_target", 1'b1, 32'h100);

    // Cycle 9: WAIT, redirect together with response
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    settle();
    chk("c9_flush", 32'(if_flush), 32'h1);

    // Cycles 10-13: response dropped, memory not ready for 4 cycles
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    settle();
    chk_slot("c10_nofill", 1'b0, 32'h0, 32'h0);
    chk_req("c10_target", 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk_req("notready_hold", 1'b1, 32'h200);
    end

    // Cycle 14: ready returns
    tick();
    imem_req_ready = 1'b1;
    settle();
    chk_req("c14_ready", 1'b1, 32'h200);

    // Cycle 15: no duplicate request, response arrives
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    settle();
    chk_req("c15_nodup", 1'b0, 32'h0);

    // Cycle 16: slot full, redirect to last word for wrap check
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    chk_slot("c16_fill", 1'b1, 32'h200, 32'h0000_0013);
    chk_req("c16_next", 1'b1, 32'h204);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    chk_req("c16_redir_suppress", 1'b0, 32'h0);

    // Cycle 17: request at 0xFFFFFFFC
    tick();
    redirect_valid = 1'b0;
    settle();
    chk_slot("c17_flushed", 1'b0, 32'h0, 32'h0);
    chk_req("c17_wrapreq", 1'b1, 32'hFFFF_FFFC);

    // Cycle 18: response
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAAAA_5555;
    settle();

    // Cycle 19: PC wraps to 0; stall and redirect together
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    chk_slot("c19_wrapfill", 1'b1, 32'hFFFF_FFFC, 32'hAAAA_5555);
    chk_req("c19_wrapaddr", 1'b1, 32'h0);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    #1;
    chk("c19_flush", 32'(if_flush), 32'h1);
    chk_req("c19_redir", 1'b0, 32'h0);

    // Cycle 20: redirect beat stall, slot cleared
    tick();
    redirect_valid = 1'b0;
    settle();
    chk_slot("c20_cleared", 1'b0, 32'h0, 32'h0);
    chk_req("c20_req", 1'b1, 32'h40);
`ifdef IF_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd3);
    chk("perf_killed", perf_killed, 32'd2);
    chk("perf_stall_cyc", perf_stall_cyc, 32'd4);
`endif

    stall = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
